// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the multi-channel APB slave bridge.
// Error-cause codes are kept in a register so debug can see why PSLVERR fired.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        RESP
    } state_e;

    localparam int CNT_WD = 16;
    localparam int ERR_WD = 3;

    localparam logic [ERR_WD-1:0] ERR_NONE    = 3'd0;
    localparam logic [ERR_WD-1:0] ERR_DECODE  = 3'd1;
    localparam logic [ERR_WD-1:0] ERR_STRB    = 3'd2;
    localparam logic [ERR_WD-1:0] ERR_BACKEND = 3'd3;
    localparam logic [ERR_WD-1:0] ERR_TIMEOUT = 3'd4;

    function automatic int chw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_bridge_mc_if.sv
// APB4 slave port plus the per-channel configuration-space back-end bundle.
// The slave modport is the bridge view; master is the interconnect/back-end view.
interface apb_slave_bridge_mc_if #(
    parameter int DATA_WD = 32,
    parameter int ADDR_WD = 16,
    parameter int NUM_CH  = 4
);
    localparam int SW = DATA_WD / 8;

    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WD-1:0]        PADDR;
    logic [DATA_WD-1:0]        PWDATA;
    logic [SW-1:0]             PSTRB;
    logic                      PREADY;
    logic [DATA_WD-1:0]        PRDATA;
    logic                      PSLVERR;

    logic [NUM_CH-1:0]         APB_Request;
    logic [NUM_CH-1:0]         APB_Grant;
    logic [ADDR_WD-1:0]        APB_OADDR;
    logic [DATA_WD-1:0]        APB_ODATA;
    logic [SW-1:0]             APB_OSTRB;
    logic                      APB_OWRITE;
    logic [NUM_CH-1:0]         ConfigSp_ACKAPB;
    logic [NUM_CH*DATA_WD-1:0] ConfigSp_DATA;
    logic                      Addr_ER;
    logic                      Parity_ER;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR,
        output APB_Request, APB_OADDR, APB_ODATA, APB_OSTRB, APB_OWRITE,
        input  APB_Grant, ConfigSp_ACKAPB, ConfigSp_DATA, Addr_ER, Parity_ER
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR,
        input  APB_Request, APB_OADDR, APB_ODATA, APB_OSTRB, APB_OWRITE,
        output APB_Grant, ConfigSp_ACKAPB, ConfigSp_DATA, Addr_ER, Parity_ER
    );

endinterface

// File: rtl/apb_bridge_timeout.sv
// Wait-state watchdog: counts busy cycles and flags the cycle in which
// the TIMEOUT-th busy cycle completes.
module apb_bridge_timeout
    import apb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              ld_i,
    input  logic [CNT_WD-1:0] ld_val_i,
    output logic              expired_o
);

    logic [CNT_WD-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds completed busy cycles, so this edge finishes cycle TIMEOUT
    assign expired_o = en_i && (cnt_q == CNT_WD'(TIMEOUT - 1));

endmodule

// File: rtl/apb_slave_bridge_mc.sv
// APB4 slave fanning out to NUM_CH configuration-space channels selected by
// PADDR, with strobe checking, a wait-state timeout and back-end error merge.
module apb_slave_bridge_mc
    import apb_bridge_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int ADDR_WD = 16,
    parameter int NUM_CH  = 4,
    parameter int CH_LSB  = 12,
    parameter int TIMEOUT = 255
) (
    input logic PCLK,
    input logic PRESET,
    apb_slave_bridge_mc_if.slave bus
);

    localparam int CHW = chw_f(NUM_CH);
    localparam int SW  = DATA_WD / 8;

    state_e              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d, ch_in;
    logic                wr_q, wr_d;
    logic [NUM_CH-1:0]   req_q, req_d, onehot;
    logic [ADDR_WD-1:0]  oaddr_q, oaddr_d;
    logic [DATA_WD-1:0]  odata_q, odata_d;
    logic [SW-1:0]       ostrb_q, ostrb_d;
    logic                owr_q, owr_d;
    logic [DATA_WD-1:0]  rdata_q, rdata_d, rsel;
    logic [ERR_WD-1:0]   cause_q, cause_d;
    logic                busy, busy_d, tmo_clr, tmo_exp;

    assign ch_in  = bus.PADDR[CH_LSB +: CHW];
    assign rsel   = bus.ConfigSp_DATA[int'(ch_q)*DATA_WD +: DATA_WD];
    assign busy   = (state_q == REQ) || (state_q == XFER);
    assign busy_d = (state_d == REQ) || (state_d == XFER);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            onehot[k] = (int'(ch_in) == k);
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        wr_d    = wr_q;
        req_d   = req_q;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        ostrb_d = ostrb_q;
        owr_d   = owr_q;
        rdata_d = '0;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    ch_d = ch_in;
                    wr_d = bus.PWRITE;
                    if (int'(ch_in) >= NUM_CH) begin
                        cause_d = ERR_DECODE;
                        state_d = RESP;
                    end else if (!bus.PWRITE && (bus.PSTRB != '0)) begin
                        cause_d = ERR_STRB;
                        state_d = RESP;
                    end else begin
                        cause_d = ERR_NONE;
                        state_d = REQ;
                        req_d   = onehot;
                        oaddr_d = bus.PADDR;
                        odata_d = bus.PWDATA;
                        ostrb_d = bus.PWRITE ? bus.PSTRB : '0;
                        owr_d   = bus.PWRITE;
                    end
                end
            end
            REQ: begin
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else if (tmo_exp) begin
                    cause_d = ERR_TIMEOUT;
                    state_d = RESP;
                end else if (bus.APB_Grant[ch_q]) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else if (bus.ConfigSp_ACKAPB[ch_q]) begin
                    // a completing ack beats a simultaneous timeout
                    state_d = RESP;
                    if (bus.Addr_ER || bus.Parity_ER) begin
                        cause_d = ERR_BACKEND;
                    end else begin
                        cause_d = ERR_NONE;
                        rdata_d = wr_q ? '0 : rsel;
                    end
                end else if (tmo_exp) begin
                    cause_d = ERR_TIMEOUT;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!busy_d) begin
            req_d   = '0;
            oaddr_d = '0;
            odata_d = '0;
            ostrb_d = '0;
            owr_d   = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            ch_q    <= '0;
            wr_q    <= 1'b0;
            req_q   <= '0;
            oaddr_q <= '0;
            odata_q <= '0;
            ostrb_q <= '0;
            owr_q   <= 1'b0;
            rdata_q <= '0;
            cause_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            wr_q    <= wr_d;
            req_q   <= req_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            ostrb_q <= ostrb_d;
            owr_q   <= owr_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
        end
    end

    assign tmo_clr = !busy_d || (state_q == IDLE);

    apb_bridge_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clr_i    (tmo_clr),
        .en_i     (busy),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .expired_o(tmo_exp)
    );

    assign bus.PREADY      = (state_q == RESP) && bus.PENABLE;
    assign bus.PSLVERR     = bus.PREADY && (cause_q != ERR_NONE);
    assign bus.PRDATA      = rdata_q;
    assign bus.APB_Request = req_q;
    assign bus.APB_OADDR   = oaddr_q;
    assign bus.APB_ODATA   = odata_q;
    assign bus.APB_OSTRB   = ostrb_q;
    assign bus.APB_OWRITE  = owr_q;

endmodule

// File: doc/apb_slave_bridge_mc.md
Name: apb_slave_bridge_mc

Overview:
- Parametrised multi-channel successor to the team's single-channel APB slave: one APB4 slave port, NUM_CH configuration-space back-end channels.
- Each channel uses its own request/grant/ack handshake. PADDR decodes the target channel.
- Adds PSTRB legality checking, a wait-state timeout, and a single-bit PSLVERR.
- Sits between the APB interconnect and the configuration-space arbiters, all on PCLK.

Parameters:
- DATA_WD, 32, APB data width; multiple of 8.
- ADDR_WD, 16, APB address width.
- NUM_CH, 4, number of back-end channels; 1..16.
- CH_LSB, 12, LSB of the channel-select field; field is PADDR[CH_LSB +: CHW], where CHW = max(1, clog2(NUM_CH)).
- TIMEOUT, 255, maximum cycles spent in REQ+XFER before an error response; 1..2^16-1.

Ports:
- PCLK  in  1  clock, all logic rising-edge.
- PRESET  in  1  asynchronous reset, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_WD  APB address.
- PWDATA  in  DATA_WD  write data.
- PSTRB  in  DATA_WD/8  write byte strobes.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WD  read data.
- PSLVERR  out  1  error response, valid only with PREADY.
- APB_Request  out  NUM_CH  one-hot request to the decoded channel.
- APB_Grant  in  NUM_CH  per-channel grant.
- APB_OADDR  out  ADDR_WD  forwarded address.
- APB_ODATA  out  DATA_WD  forwarded write data.
- APB_OSTRB  out  DATA_WD/8  forwarded strobes.
- APB_OWRITE  out  1  forwarded direction.
- ConfigSp_ACKAPB  in  NUM_CH  per-channel completion ack.
- ConfigSp_DATA  in  NUM_CH*DATA_WD  per-channel read data; channel k occupies bits [k*DATA_WD +: DATA_WD].
- Addr_ER  in  1  back-end address error, sampled with ack.
- Parity_ER  in  1  back-end parity error, sampled with ack.

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; capture registers 0.
- Reset mid-transaction drops the request immediately and raises no PREADY.
- States: IDLE, REQ, XFER, RESP.
- IDLE:
  - On PSEL=1 & PENABLE=0 at edge E0, capture PADDR, PWDATA, PSTRB, PWRITE and ch.
  - If ch>=NUM_CH, or a read has PSTRB!=0: go to RESP with err=1, no back-end request.
  - Otherwise go to REQ.
- Back-end outputs are registered and driven from REQ entry until RESP entry.
  - APB_OSTRB = captured PSTRB on writes, 0 on reads.
  - APB_Request[ch] is the only request bit set.
- REQ: APB_Grant[ch]=1 -> XFER. Grants and acks on other channels are ignored. An ack on ch before grant is ignored.
- XFER: ConfigSp_ACKAPB[ch]=1 -> RESP. On that edge:
  - err = Addr_ER | Parity_ER.
  - Reads capture ConfigSp_DATA slice ch into PRDATA.
- Timeout counter:
  - Cleared on REQ entry; increments every REQ/XFER cycle.
  - When it equals TIMEOUT, go to RESP with err=1 and PRDATA=0.
  - Ack and timeout in the same cycle: ack wins.
- RESP: PREADY=1 and PSLVERR=err for exactly one cycle, then IDLE. APB_Request is 0 during RESP.
- PRDATA: 0 outside RESP, 0 for writes, 0 on any error.
- Minimum latency, with grant and ack high at the first opportunity:
  - Request high after E0; grant sampled E1; ack sampled E2.
  - PREADY high between E2 and E3.
- Protocol violation: PSEL=0 while in REQ/XFER -> IDLE next edge, request dropped, no PREADY, counter cleared.
- PREADY never asserts while PENABLE=0.
- Back-to-back transfers: a new setup is accepted in the IDLE cycle following RESP; no cycle is skipped.
- Write with PSTRB=0 is forwarded unchanged and is not an error.

Decomposition:
- Package apb_bridge_pkg:
  - State enum (IDLE, REQ, XFER, RESP).
  - clog2-based CHW function.
  - Localparams for error causes (DECODE, STRB, BACKEND, TIMEOUT), used by the internal err_cause register for debug visibility.
- One sub-module: apb_bridge_timeout.
  - Loadable counter with clear, enable and an expired flag, parametrised by TIMEOUT.
  - Instantiated once.

Test Plan:
- Write: data 152, addr 0x100C (ch1), PSTRB 4'b1111; grant 3 cycles after request, ack 2 cycles later -> APB_Request=4'b0010, APB_ODATA=152, APB_OSTRB=4'hF; PREADY one cycle; PSLVERR=0; PRDATA=0.
- Read: addr 0x3022 (ch3), PSTRB 0; ConfigSp_DATA ch3=150 with ack -> PRDATA=150 with PREADY, PSLVERR=0; request bit 3 only.
- Read with PSTRB=4'b0011 -> no request; PREADY the cycle after the access phase begins; PSLVERR=1; PRDATA=0. NUM_CH=3 with addr 0x3000 -> same error response.
- Grant never arrives, TIMEOUT=8 -> request held 8 cycles, then PREADY with PSLVERR=1. Repeat with ack in the expiry cycle -> PSLVERR=0 and data returned.
- Ack with Parity_ER=1 on a read -> PSLVERR=1, PRDATA=0. An ack on ch2 while targeting ch0 is ignored.
- PRESET asserted in XFER -> all outputs 0 immediately, no PREADY. PSEL dropped in REQ -> request low next cycle. A back-to-back write then read both complete correctly.
